// File: rtl/data_port_arbiter.sv
// data_port_arbiter: shares one 33-bit OBI data port between two masters.
// Arbitrates the request phase (round-robin or fixed priority), keeps request
// fields stable while a stalled request is held, tracks outstanding
// transactions in an in-order ID FIFO and steers each response back to the
// master that issued it.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   m_req/m_we/m_be/m_is_cap/
//   m_addr/m_wdata/m_flag       per-master request fields (index = master id)
//   m_gnt, m_rvalid             per-master grant / response valid
//   m_rdata, m_err              shared response payload, qualified by m_rvalid
//   s_req/s_we/s_be/s_is_cap/
//   s_addr/s_wdata/s_flag       downstream request fields
//   s_gnt, s_rvalid, s_rdata,
//   s_err                       downstream grant and response
//   outst_cnt                   outstanding transaction count
//   proto_err                   sticky protocol-violation flag
module data_port_arbiter #(
  parameter int unsigned MAX_OUTST  = 2,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       m_req,
  input  logic [1:0]       m_we,
  input  logic [1:0][3:0]  m_be,
  input  logic [1:0]       m_is_cap,
  input  logic [1:0][31:0] m_addr,
  input  logic [1:0][32:0] m_wdata,
  input  logic [1:0][7:0]  m_flag,
  output logic [1:0]       m_gnt,
  output logic [1:0]       m_rvalid,
  output logic [32:0]      m_rdata,
  output logic             m_err,
  output logic             s_req,
  output logic             s_we,
  output logic [3:0]       s_be,
  output logic             s_is_cap,
  output logic [31:0]      s_addr,
  output logic [32:0]      s_wdata,
  output logic [7:0]       s_flag,
  input  logic             s_gnt,
  input  logic             s_rvalid,
  input  logic [32:0]      s_rdata,
  input  logic             s_err,
  output logic [3:0]       outst_cnt,
  output logic             proto_err
);

  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = 4;

  logic                 last_q, last_d;
  logic                 hold_q, hold_d;
  logic                 hold_id_q, hold_id_d;
  logic                 perr_q, perr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [MAX_OUTST-1:0] id_q, id_d;

  logic sel_c, src_c, hold_drop_c, full_c, push_c, pop_c, head_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Master selection: a held request keeps its master, else arbitrate.
  always_comb begin
    sel_c = 1'b0;
    if (hold_q) begin
      sel_c = hold_id_q;
    end else begin
      case (m_req)
        2'b10:   sel_c = 1'b1;
        2'b11:   sel_c = FIXED_PRIO ? 1'b0 : ~last_q;
        default: sel_c = 1'b0;
      endcase
    end
  end

  assign hold_drop_c = hold_q & ~m_req[hold_id_q];
  // A pop in the same cycle does not relieve a full FIFO until the next cycle.
  assign full_c      = (cnt_q >= CW'(MAX_OUTST));
  assign s_req       = rst_n & m_req[sel_c] & ~hold_drop_c & ~full_c;
  assign push_c      = s_req & s_gnt;
  assign pop_c       = rst_n & s_rvalid & (cnt_q != '0);
  assign head_c      = id_q[rptr_q];

  // Downstream fields default to master 0 when nothing is requested.
  assign src_c    = s_req ? sel_c : 1'b0;
  assign s_we     = m_we[src_c];
  assign s_be     = m_be[src_c];
  assign s_is_cap = m_is_cap[src_c];
  assign s_addr   = m_addr[src_c];
  assign s_wdata  = m_wdata[src_c];
  assign s_flag   = m_flag[src_c];

  assign m_gnt    = {push_c & sel_c, push_c & ~sel_c};
  assign m_rvalid = {pop_c & head_c, pop_c & ~head_c};
  assign m_rdata  = s_rdata;
  assign m_err    = s_err;

  assign outst_cnt = cnt_q;
  assign proto_err = perr_q;

  // Next-state: ID FIFO, count, hold tracking, round-robin pointer, errors.
  always_comb begin
    last_d    = last_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    perr_d    = perr_q;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    id_d      = id_q;

    if (push_c) begin
      id_d[wptr_q] = sel_c;
      wptr_d       = ptr_inc(wptr_q);
      last_d       = sel_c;
    end
    if (pop_c) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Response with nothing outstanding is dropped and flagged.
    if (s_rvalid && (cnt_q == '0)) begin
      perr_d = 1'b1;
    end

    if (hold_drop_c) begin
      hold_d = 1'b0;
      perr_d = 1'b1;
    end else if (s_req && !s_gnt) begin
      hold_d    = 1'b1;
      hold_id_d = sel_c;
    end else if (push_c) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      hold_q    <= 1'b0;
      hold_id_q <= 1'b0;
      perr_q    <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      id_q      <= '0;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      perr_q    <= perr_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      id_q      <= id_d;
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
module tb_data_port_arbiter;

  typedef struct {
    logic        id;
    logic [32:0] data;
    logic        err;
  } rsp_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       m_req;
  logic [1:0]       m_we;
  logic [1:0][3:0]  m_be;
  logic [1:0]       m_is_cap;
  logic [1:0][31:0] m_addr;
  logic [1:0][32:0] m_wdata;
  logic [1:0][7:0]  m_flag;
  logic             s_gnt;
  logic             s_rvalid;
  logic [32:0]      s_rdata;
  logic             s_err;

  logic [1:0]  m_gnt, m_rvalid;
  logic [32:0] m_rdata;
  logic        m_err, s_req, s_we, s_is_cap;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [32:0] s_wdata;
  logic [7:0]  s_flag;
  logic [3:0]  outst_cnt;
  logic        proto_err;

  logic [1:0]  fp_m_gnt, fp_m_rvalid;
  logic [32:0] fp_m_rdata;
  logic        fp_m_err, fp_s_req, fp_s_we, fp_s_is_cap;
  logic [3:0]  fp_s_be;
  logic [31:0] fp_s_addr;
  logic [32:0] fp_s_wdata;
  logic [7:0]  fp_s_flag;
  logic [3:0]  fp_outst_cnt;
  logic        fp_proto_err;

  int n_chk;
  int n_pass;
  rsp_t exp_q[$];

  data_port_arbiter #(.MAX_OUTST(2), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_be(m_be),
    .m_is_cap(m_is_cap), .m_addr(m_addr), .m_wdata(m_wdata), .m_flag(m_flag),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_is_cap(s_is_cap),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_flag(s_flag), .s_gnt(s_gnt),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .outst_cnt(outst_cnt), .proto_err(proto_err)
  );

  data_port_arbiter #(.MAX_OUTST(2), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_be(m_be),
    .m_is_cap(m_is_cap), .m_addr(m_addr), .m_wdata(m_wdata), .m_flag(m_flag),
    .m_gnt(fp_m_gnt), .m_rvalid(fp_m_rvalid), .m_rdata(fp_m_rdata), .m_err(fp_m_err),
    .s_req(fp_s_req), .s_we(fp_s_we), .s_be(fp_s_be), .s_is_cap(fp_s_is_cap),
    .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_flag(fp_s_flag), .s_gnt(s_gnt),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .outst_cnt(fp_outst_cnt), .proto_err(fp_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m_req    = 2'b00;
    m_we     = 2'b00;
    m_be     = '1;
    m_is_cap = 2'b00;
    m_flag   = '0;
    m_wdata  = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_err    = 1'b0;
  endtask

  // Pulses reset and returns at a falling edge with the DUTs idle.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    m_req = 2'b11;
    s_gnt = 1'b1;
    s_rvalid = 1'b1;
    #1;
    n_chk++; if (m_gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", m_gnt); else n_pass++;
    n_chk++; if (m_rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", m_rvalid); else n_pass++;
    n_chk++; if (s_req !== 1'b0) $display("FAIL reset_s_req: got %b want 0", s_req); else n_pass++;
    n_chk++; if (outst_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", outst_cnt); else n_pass++;
    n_chk++; if (proto_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", proto_err); else n_pass++;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    rsp_t e;
    do_reset();
    m_req = 2'b01;
    m_addr[0] = 32'h8000_0010;
    m_addr[1] = 32'h1111_1110;
    s_gnt = 1'b1;
    #1;
    n_chk++; if (m_gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", m_gnt); else n_pass++;
    n_chk++; if (s_addr !== 32'h8000_0010) $display("FAIL single_addr: got %h want 80000010", s_addr); else n_pass++;
    exp_q.push_back('{id: 1'b0, data: 33'h0_1234_5678, err: 1'b0});
    @(negedge clk);
    m_req = 2'b00;
    s_gnt = 1'b0;
    n_chk++; if (outst_cnt !== 4'd1) $display("FAIL single_cnt1: got %0d want 1", outst_cnt); else n_pass++;
    e = exp_q.pop_front();
    s_rvalid = 1'b1;
    s_rdata = e.data;
    s_err = e.err;
    #1;
    n_chk++; if (m_rvalid !== (e.id ? 2'b10 : 2'b01)) $display("FAIL single_rvalid: got %b want %b", m_rvalid, (e.id ? 2'b10 : 2'b01)); else n_pass++;
    n_chk++; if (m_rdata !== 33'h0_1234_5678) $display("FAIL single_rdata: got %h want 012345678", m_rdata); else n_pass++;
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_chk++; if (outst_cnt !== 4'd0) $display("FAIL single_cnt0: got %0d want 0", outst_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    rsp_t e;
    logic [1:0] want;
    int fp_m0;
    fp_m0 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_req = 2'b11;
      s_gnt = 1'b1;
      s_rvalid = 1'b0;
      want = 2'b00;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s_rvalid = 1'b1;
        s_rdata = e.data;
        s_err = e.err;
        want = e.id ? 2'b10 : 2'b01;
      end
      #1;
      n_chk++; if (m_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL rr_gnt%0d: got %b want %b", k, m_gnt, ((k % 2 == 0) ? 2'b01 : 2'b10)); else n_pass++;
      n_chk++; if (m_rvalid !== want) $display("FAIL rr_rvalid%0d: got %b want %b", k, m_rvalid, want); else n_pass++;
      n_chk++; if (outst_cnt > 4'd1) $display("FAIL rr_cnt%0d: got %0d want <=1", k, outst_cnt); else n_pass++;
      if (fp_m_gnt === 2'b01) fp_m0++;
      exp_q.push_back('{id: (k % 2 == 1), data: 33'($urandom), err: 1'b0});
      @(negedge clk);
    end
    m_req = 2'b00;
    s_gnt = 1'b0;
    e = exp_q.pop_front();
    s_rvalid = 1'b1;
    s_rdata = e.data;
    #1;
    n_chk++; if (m_rvalid !== 2'b10 || m_rdata !== e.data) $display("FAIL rr_drain: got %b/%h want 10/%h", m_rvalid, m_rdata, e.data); else n_pass++;
    n_chk++; if (fp_m0 !== 4) $display("FAIL fp_m0_wins: got %0d want 4", fp_m0); else n_pass++;
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic test_stall();
    rsp_t e;
    do_reset();
    m_addr[0] = 32'hB000_0000;
    m_addr[1] = 32'hA000_0004;
    m_req = 2'b10;
    s_gnt = 1'b0;
    #1;
    n_chk++; if (s_req !== 1'b1 || s_addr !== 32'hA000_0004) $display("FAIL stall_first: got %b/%h want 1/a0000004", s_req, s_addr); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      m_req = 2'b11;
      #1;
      n_chk++; if (s_addr !== 32'hA000_0004 || m_gnt !== 2'b00) $display("FAIL stall_hold%0d: got %h/%b want a0000004/00", k, s_addr, m_gnt); else n_pass++;
    end
    @(negedge clk);
    s_gnt = 1'b1;
    #1;
    n_chk++; if (m_gnt !== 2'b10) $display("FAIL stall_gnt: got %b want 10", m_gnt); else n_pass++;
    exp_q.push_back('{id: 1'b1, data: 33'h1_0000_00AA, err: 1'b0});
    @(negedge clk);
    m_req = 2'b00;
    s_gnt = 1'b0;
    e = exp_q.pop_front();
    s_rvalid = 1'b1;
    s_rdata = e.data;
    #1;
    n_chk++; if (m_rvalid !== 2'b10) $display("FAIL stall_rsp: got %b want 10", m_rvalid); else n_pass++;
    n_chk++; if (proto_err !== 1'b0) $display("FAIL stall_perr: got %b want 0", proto_err); else n_pass++;
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic test_full();
    rsp_t e;
    do_reset();
    s_gnt = 1'b1;
    m_req = 2'b01;
    #1;
    n_chk++; if (m_gnt !== 2'b01) $display("FAIL full_g0: got %b want 01", m_gnt); else n_pass++;
    exp_q.push_back('{id: 1'b0, data: 33'h0_0000_0F00, err: 1'b1});
    @(negedge clk);
    m_req = 2'b10;
    #1;
    n_chk++; if (m_gnt !== 2'b10) $display("FAIL full_g1: got %b want 10", m_gnt); else n_pass++;
    exp_q.push_back('{id: 1'b1, data: 33'h1_0000_0F01, err: 1'b0});
    @(negedge clk);
    m_req = 2'b11;
    #1;
    n_chk++; if (s_req !== 1'b0 || m_gnt !== 2'b00) $display("FAIL full_block: got %b/%b want 0/00", s_req, m_gnt); else n_pass++;
    n_chk++; if (outst_cnt !== 4'd2) $display("FAIL full_cnt: got %0d want 2", outst_cnt); else n_pass++;
    e = exp_q.pop_front();
    s_rvalid = 1'b1;
    s_rdata = e.data;
    s_err = e.err;
    #1;
    n_chk++; if (s_req !== 1'b0) $display("FAIL full_samepop: got %b want 0", s_req); else n_pass++;
    n_chk++; if (m_rvalid !== (e.id ? 2'b10 : 2'b01) || m_err !== e.err) $display("FAIL full_rsp0: got %b/%b want %b/%b", m_rvalid, m_err, (e.id ? 2'b10 : 2'b01), e.err); else n_pass++;
    @(negedge clk);
    m_req = 2'b00;
    s_gnt = 1'b0;
    e = exp_q.pop_front();
    s_rdata = e.data;
    s_err = e.err;
    #1;
    n_chk++; if (m_rvalid !== (e.id ? 2'b10 : 2'b01) || m_err !== e.err || m_rdata !== e.data) $display("FAIL full_rsp1: got %b/%b/%h want %b/%b/%h", m_rvalid, m_err, m_rdata, (e.id ? 2'b10 : 2'b01), e.err, e.data); else n_pass++;
    @(negedge clk);
    s_rvalid = 1'b0;
    s_err = 1'b0;
    #1;
    n_chk++; if (outst_cnt !== 4'd0) $display("FAIL full_drain: got %0d want 0", outst_cnt); else n_pass++;
  endtask

  task automatic test_violations();
    do_reset();
    s_rvalid = 1'b1;
    #1;
    n_chk++; if (m_rvalid !== 2'b00) $display("FAIL spur_rvalid: got %b want 00", m_rvalid); else n_pass++;
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_chk++; if (proto_err !== 1'b1 || outst_cnt !== 4'd0) $display("FAIL spur_perr: got %b/%0d want 1/0", proto_err, outst_cnt); else n_pass++;

    do_reset();
    n_chk++; if (proto_err !== 1'b0) $display("FAIL perr_clear: got %b want 0", proto_err); else n_pass++;
    m_req = 2'b01;
    s_gnt = 1'b0;
    @(negedge clk);
    m_req = 2'b00;
    #1;
    n_chk++; if (s_req !== 1'b0) $display("FAIL drop_sreq: got %b want 0", s_req); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (proto_err !== 1'b1) $display("FAIL drop_perr: got %b want 1", proto_err); else n_pass++;

    do_reset();
    s_gnt = 1'b1;
    m_req = 2'b01;
    @(negedge clk);
    m_req = 2'b10;
    @(negedge clk);
    m_req = 2'b00;
    s_gnt = 1'b0;
    #1;
    n_chk++; if (outst_cnt !== 4'd2) $display("FAIL mid_cnt: got %0d want 2", outst_cnt); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (outst_cnt !== 4'd0 || proto_err !== 1'b0) $display("FAIL mid_reset: got %0d/%b want 0/0", outst_cnt, proto_err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    s_rvalid = 1'b1;
    #1;
    n_chk++; if (m_rvalid !== 2'b00) $display("FAIL late_rsp: got %b want 00", m_rvalid); else n_pass++;
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    n_chk++; if (proto_err !== 1'b1 || outst_cnt !== 4'd0) $display("FAIL late_perr: got %b/%0d want 1/0", proto_err, outst_cnt); else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    idle_inputs();
    m_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_full();
    test_violations();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Two-master arbiter for the single 33-bit OBI data port that feeds data_mem_model. Shares it between master 0 (the core LSU port) and master 1 (the TBRE/stack-zeroing engine or a bench DMA agent).
- Arbitrates the request phase, tracks outstanding transactions in order, and routes each response back to the master that issued it.
- Sits in the testbench between the core/agents and the memory model.

Parameters:
- MAX_OUTST, 2, maximum number of granted transactions awaiting rvalid (1..8).
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins a tie.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  2  per-master request; bit i belongs to master i.
- m_we  in  2  per-master write enable.
- m_be  in  2x4  per-master byte enables, packed.
- m_is_cap  in  2  per-master capability access.
- m_addr  in  2x32  per-master byte address.
- m_wdata  in  2x33  per-master write data, tag in bit 32.
- m_flag  in  2x8  per-master flags.
- m_gnt  out  2  per-master grant.
- m_rvalid  out  2  per-master response valid.
- m_rdata  out  33  response data, shared; qualified by m_rvalid.
- m_err  out  1  response error, shared; qualified by m_rvalid.
- s_req  out  1  downstream request.
- s_we  out  1  downstream write enable, muxed from the selected master.
- s_be  out  4  downstream byte enables, muxed from the selected master.
- s_is_cap  out  1  downstream capability flag, muxed from the selected master.
- s_addr  out  32  downstream address, muxed from the selected master.
- s_wdata  out  33  downstream write data, muxed from the selected master.
- s_flag  out  8  downstream flags, muxed from the selected master.
- s_gnt  in  1  downstream grant.
- s_rvalid  in  1  downstream response valid.
- s_rdata  in  33  downstream read data.
- s_err  in  1  downstream error.
- outst_cnt  out  4  number of outstanding transactions.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values:
  - outst_cnt = 0, proto_err = 0.
  - Round-robin pointer favours master 0.
  - hold_q = 0; ID FIFO empty.
  - While rst_n is low, m_gnt, m_rvalid and s_req are 0.
- Selection, combinational:
  - If hold_q = 1, sel = hold_id_q.
  - Otherwise, with exactly one m_req high, sel = that master.
  - With both high: FIXED_PRIO = 1 gives sel = 0; otherwise sel = the master not granted last.
- s_req = (m_req[sel] & ~hold_drop) & (outst_cnt < MAX_OUTST). Here hold_drop = hold_q & ~m_req[hold_id_q].
- The selected master's fields drive s_*. When s_req = 0, s_* fields carry master 0's values.
- m_gnt[sel] = s_req & s_gnt, zero-cycle latency; the other m_gnt bit is 0.
- Hold (request stability):
  - If s_req = 1 and s_gnt = 0, set hold_q = 1 and hold_id_q = sel on the next edge.
  - Clear hold_q on the grant.
  - If the held master drops its req before grant: clear hold_q, set proto_err, and issue no request that cycle.
- Full:
  - While outst_cnt == MAX_OUTST, s_req = 0 regardless of m_req.
  - A same-cycle pop does not unblock; the request is issued the next cycle.
- ID FIFO:
  - Depth MAX_OUTST; each entry holds the 1-bit master id.
  - On s_req & s_gnt, push sel.
  - On s_rvalid, pop the head. Drive m_rvalid[head] = 1 in the same cycle, m_rdata = s_rdata, m_err = s_err.
  - Responses are strictly in order. Pointers wrap modulo MAX_OUTST.
  - outst_cnt = pushes - pops. On simultaneous push and pop the count is unchanged.
  - A single cycle may carry both a push and a pop, including a grant to one master while the other receives a response.
- Spurious response: s_rvalid with outst_cnt == 0 sets proto_err, leaves m_rvalid = 0 and causes no underflow.
- Round-robin pointer: on each grant, last = sel. It does not change while hold_q = 1.
- proto_err clears only on reset.
- Reset mid-operation: all outstanding tracking is discarded. Responses arriving after reset follow the spurious-response rule.

Test Plan:
- Single master: m_req = 01, s_gnt = 1, addr 0x8000_0010 → m_gnt = 01 in the same cycle. s_rvalid one cycle later with rdata 0x0_1234_5678 → m_rvalid = 01, m_rdata = 0x0_1234_5678.
- Round-robin contention: both masters requesting continuously, s_gnt = 1, rvalid one cycle after each grant → grants alternate 01, 10, 01, 10; outst_cnt never exceeds 1. Repeat with FIXED_PRIO = 1 → master 0 granted 4 of 4.
- Stall/hold: master 1 selected, s_gnt = 0 for 3 cycles, master 0 raises req during the stall → s_addr holds master 1's value; first grant goes to master 1; proto_err stays 0.
- Full plus in-order routing: MAX_OUTST = 2, grants m0 then m1, no rvalid → 3rd request blocked with s_req = 0 and outst_cnt = 2. Two rvalids with err = 1 then 0 → m_rvalid = 01 with err 1, then 10 with err 0.
- Violations: s_rvalid with an empty FIFO → proto_err = 1, m_rvalid = 00. Separately, the held master drops req before grant → proto_err = 1. Assert rst_n low with 2 outstanding → outst_cnt = 0 and proto_err = 0 after reset.
